// File: rtl/nonconsec_seq_gen_pkg.sv
// Shared types for the non-consecutive repetition stimulus generator.
// Optional build macro NCSEQ_ERR_INJECT_EN is handled in the interface and top.
package nonconsec_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PULSE_B = 3'd1,
        GAP     = 3'd2,
        TAIL    = 3'd3,
        PULSE_C = 3'd4
    } state_t;

    // Pulse counter must hold COUNT+1 for the error-injection variant.
    function automatic int cnt_w(int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/nonconsec_seq_gen_if.sv
// Request/pulse bundle between a sequence requester and nonconsec_seq_gen.
// With NCSEQ_ERR_INJECT_EN defined the bundle carries the inject request bit.
interface nonconsec_seq_gen_if #(
    parameter int GAP_W = 4
);
    logic             start;
    logic [GAP_W-1:0] gap;
    logic [GAP_W-1:0] tail;
`ifdef NCSEQ_ERR_INJECT_EN
    logic             inject;
`endif
    logic             b;
    logic             c;
    logic             busy;

`ifdef NCSEQ_ERR_INJECT_EN
    modport master (output start, gap, tail, inject, input b, c, busy);
    modport slave  (input start, gap, tail, inject, output b, c, busy);
`else
    modport master (output start, gap, tail, input b, c, busy);
    modport slave  (input start, gap, tail, output b, c, busy);
`endif
endinterface

// File: rtl/nonconsec_seq_gen_dwell_cnt.sv
// Loadable down-counter used for both the inter-pulse gap and the tail dwell.
// Saturates at zero so it can never wrap.
module nonconsec_dwell_cnt #(
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             load,
    input  logic             dec,
    input  logic [GAP_W-1:0] load_val,
    output logic             zero
);
    logic [GAP_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - GAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/nonconsec_seq_gen.sv
// Driver for the a |-> b[=N] ##1 c protocol: N spaced b pulses, a tail, then c.
// Define NCSEQ_ERR_INJECT_EN to add an inject request that emits COUNT+1 pulses.
module nonconsec_seq_gen
    import nonconsec_seq_pkg::*;
#(
    parameter int COUNT = 3,
    parameter int GAP_W = 4
) (
    input logic               clk,
    input logic               rst,
    nonconsec_seq_gen_if.slave bus
);
    localparam int CW = cnt_w(COUNT);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc, target;
    logic [GAP_W-1:0] gapm1_q, gapm1_d, tail_q, tail_d;
    logic             b_q, b_d, c_q, c_d, busy_q, busy_d;
    logic             dw_load, dw_dec, dw_zero;
    logic [GAP_W-1:0] dw_val;

`ifdef NCSEQ_ERR_INJECT_EN
    logic inj_q, inj_d;
    assign target = inj_q ? CW'(COUNT + 1) : CW'(COUNT);
`else
    assign target = CW'(COUNT);
`endif

    assign cnt_inc = cnt_q + CW'(1);

    // Dwell counter is loaded with hold-length minus one so 'zero' marks the last hold cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gapm1_d = gapm1_q;
        tail_d  = tail_q;
`ifdef NCSEQ_ERR_INJECT_EN
        inj_d   = inj_q;
`endif
        dw_load = 1'b0;
        dw_dec  = 1'b0;
        dw_val  = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    gapm1_d = (bus.gap == '0) ? '0 : bus.gap - GAP_W'(1);
                    tail_d  = bus.tail;
                    cnt_d   = '0;
`ifdef NCSEQ_ERR_INJECT_EN
                    inj_d   = bus.inject;
`endif
                    state_d = PULSE_B;
                end
            end
            PULSE_B: begin
                cnt_d   = cnt_inc;
                dw_load = 1'b1;
                if (cnt_inc == target) begin
                    dw_val  = tail_q - GAP_W'(1);
                    state_d = (tail_q == '0) ? PULSE_C : TAIL;
                end else begin
                    dw_val  = gapm1_q;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (dw_zero) state_d = PULSE_B;
                else         dw_dec  = 1'b1;
            end
            TAIL: begin
                if (dw_zero) state_d = PULSE_C;
                else         dw_dec  = 1'b1;
            end
            PULSE_C: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state, so they align with state_q.
    always_comb begin
        b_d    = (state_d == PULSE_B);
        c_d    = (state_d == PULSE_C);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        gapm1_q <= gapm1_d;
        tail_q  <= tail_d;
`ifdef NCSEQ_ERR_INJECT_EN
        inj_q   <= inj_d;
`endif
    end

    nonconsec_dwell_cnt #(.GAP_W(GAP_W)) u_dwell (
        .clk      (clk),
        .load     (dw_load),
        .dec      (dw_dec),
        .load_val (dw_val),
        .zero     (dw_zero)
    );

    assign bus.b    = b_q;
    assign bus.c    = c_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_nonconsec_seq_gen.sv
// Scoreboard bench for nonconsec_seq_gen: directed sequences with hand-computed pulse edges.
// Edge numbers are relative to the edge E0 that samples start high.
module tb_nonconsec_seq_gen;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    typedef struct { bit is_c; int stamp; } ev_t;
    typedef struct { int lo; int hi; } win_t;
    ev_t  evq[$];
    win_t bq[$];

    nonconsec_seq_gen_if #(.GAP_W(4)) bus ();

    nonconsec_seq_gen #(.COUNT(3), .GAP_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic push_b(input int e0, input int rel);
        evq.push_back('{1'b0, e0 + rel});
    endtask

    task automatic push_c(input int e0, input int rel);
        evq.push_back('{1'b1, e0 + rel});
    endtask

    task automatic push_busy(input int e0, input int lo, input int hi);
        bq.push_back('{e0 + lo, e0 + hi});
    endtask

    // A value seen at the negedge after posedge k is what edge k+1 samples.
    always @(negedge clk) begin : monitor
        int   stamp;
        int   eb;
        ev_t  e;
        stamp = cyc + 1;
        if (bus.b || bus.c) begin
            chk("bc_exclusive", int'(bus.b && bus.c), 0);
            if (evq.size() == 0) begin
                chk(bus.b ? "extra_b" : "extra_c", stamp, -1);
            end else begin
                e = evq.pop_front();
                chk(bus.c ? "kind_c" : "kind_b", int'(bus.c), int'(e.is_c));
                chk(e.is_c ? "c_edge" : "b_edge", stamp, e.stamp);
            end
        end
        while (bq.size() > 0 && bq[0].hi < stamp) void'(bq.pop_front());
        eb = (bq.size() > 0 && stamp >= bq[0].lo && stamp <= bq[0].hi) ? 1 : 0;
        chk("busy", int'(bus.busy), eb);
    end

    task automatic start_seq(input int g, input int t, output int e0);
        @(negedge clk);
        bus.gap   = 4'(g);
        bus.tail  = 4'(t);
        bus.start = 1'b1;
        e0 = cyc + 1;
    endtask

    task automatic release_start();
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        chk("pending_events", evq.size(), 0);
    endtask

    initial begin : stim
        int e0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.gap   = '0;
        bus.tail  = '0;
`ifdef NCSEQ_ERR_INJECT_EN
        bus.inject = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("reset_b", int'(bus.b), 0);
        chk("reset_c", int'(bus.c), 0);
        chk("reset_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal: gap=2, tail=1
        start_seq(2, 1, e0);
        push_b(e0, 1); push_b(e0, 4); push_b(e0, 7); push_c(e0, 9); push_busy(e0, 1, 9);
        release_start();
        settle(15);

        // Minimum spacing: gap clamped to 1, tail 0
        start_seq(0, 0, e0);
        push_b(e0, 1); push_b(e0, 3); push_b(e0, 5); push_c(e0, 6); push_busy(e0, 1, 6);
        release_start();
        settle(12);

        // Start held high through E19: only E0 and E10 are accepted
        start_seq(2, 1, e0);
        push_b(e0, 1);  push_b(e0, 4);  push_b(e0, 7);  push_c(e0, 9);  push_busy(e0, 1, 9);
        push_b(e0, 11); push_b(e0, 14); push_b(e0, 17); push_c(e0, 19); push_busy(e0, 11, 19);
        repeat (20) @(negedge clk);
        bus.start = 1'b0;
        settle(10);

        // Inputs changed after acceptance must not matter: gap=1, tail=3
        start_seq(1, 3, e0);
        push_b(e0, 1); push_b(e0, 3); push_b(e0, 5); push_c(e0, 9); push_busy(e0, 1, 9);
        release_start();
        bus.gap  = 4'd7;
        bus.tail = 4'd0;
        settle(15);

        // Maximum dwell: gap=15, tail=15
        start_seq(15, 15, e0);
        push_b(e0, 1); push_b(e0, 17); push_b(e0, 33); push_c(e0, 49); push_busy(e0, 1, 49);
        release_start();
        settle(55);

        // Reset between the 2nd and 3rd b
        start_seq(2, 1, e0);
        push_b(e0, 1); push_b(e0, 4); push_busy(e0, 1, 5);
        release_start();
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_b", int'(bus.b), 0);
        chk("midrst_c", int'(bus.c), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        settle(20);

`ifdef NCSEQ_ERR_INJECT_EN
        // Injected sequence: COUNT+1 pulses
        bus.inject = 1'b1;
        start_seq(2, 1, e0);
        push_b(e0, 1); push_b(e0, 4); push_b(e0, 7); push_b(e0, 10); push_c(e0, 12);
        push_busy(e0, 1, 12);
        release_start();
        bus.inject = 1'b0;
        settle(16);
`endif

        // Recovery after reset (and after injection, when built in)
        start_seq(2, 1, e0);
        push_b(e0, 1); push_b(e0, 4); push_b(e0, 7); push_c(e0, 9); push_busy(e0, 1, 9);
        release_start();
        settle(15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
